// File: rtl/pim_pkg.sv
// pim_pkg: shared types and constants for the PIM DMA controller.
package pim_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        DONE
    } dma_state_e;

endpackage

// File: rtl/pim_dma_ctrl.sv
// pim_dma_ctrl: copies i_len words from DMEM to the PIM write port,
// one read/write pair at a time, stalling the core while busy.
module pim_dma_ctrl
    import pim_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_src_addr,
    input  logic [ADDR_W-1:0]   i_dst_addr,
    input  logic [LEN_W-1:0]    i_len,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_dmem_req,
    output logic [ADDR_W-1:0]   o_dmem_addr,
    input  logic                i_dmem_gnt,
    input  logic                i_dmem_rvalid,
    input  logic [DATA_W-1:0]   i_dmem_rdata,
    output logic                o_pim_valid,
    output logic [ADDR_W-1:0]   o_pim_addr,
    output logic [DATA_W-1:0]   o_pim_wdata,
    output logic [DATA_W/8-1:0] o_pim_wstrb,
    input  logic                i_pim_ready
);

    dma_state_e        state;
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            cnt   <= '0;
            data  <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    src   <= i_src_addr;
                    dst   <= i_dst_addr;
                    cnt   <= i_len;
                    state <= (i_len == '0) ? DONE : RD_REQ;
                end
                RD_REQ: if (i_dmem_gnt) state <= RD_WAIT;
                RD_WAIT: if (i_dmem_rvalid) begin
                    data  <= i_dmem_rdata;
                    state <= WR;
                end
                WR: if (i_pim_ready) begin
                    src   <= src + ADDR_W'(WORD_BYTES);
                    dst   <= dst + ADDR_W'(WORD_BYTES);
                    cnt   <= cnt - LEN_W'(1);
                    state <= (cnt == LEN_W'(1)) ? DONE : RD_REQ;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register only, so they drop with the async reset.
    assign o_busy      = state != IDLE;
    assign o_done      = state == DONE;
    assign o_dmem_req  = state == RD_REQ;
    assign o_dmem_addr = o_dmem_req ? src : '0;
    assign o_pim_valid = state == WR;
    assign o_pim_addr  = o_pim_valid ? dst : '0;
    assign o_pim_wdata = o_pim_valid ? data : '0;
    assign o_pim_wstrb = {(DATA_W/8){o_pim_valid}};

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// tb_pim_dma_ctrl: directed and randomized transfers checked against a
// word-list model of the copy (expected read/write sequences and cycle counts).
module tb_pim_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, dmem_req, pim_valid;
    logic [31:0] dmem_addr, pim_addr, pim_wdata;
    logic [3:0]  pim_wstrb;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0, pim_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int total = 0;
    int bad = 0;

    pim_dma_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_len(len),
        .o_busy(busy), .o_done(done),
        .o_dmem_req(dmem_req), .o_dmem_addr(dmem_addr),
        .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
        .o_pim_valid(pim_valid), .o_pim_addr(pim_addr), .o_pim_wdata(pim_wdata),
        .o_pim_wstrb(pim_wstrb), .i_pim_ready(pim_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer: model the expected word lists and per-word handshake delays,
    // then play arbiter/memory/PIM cycle by cycle, comparing every cycle.
    // restart_at: -1 none, 0 random cycle, >0 fixed cycle for an ignored second start.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n,
                       input int gmax, input int pmax, input int rmax, input bit fixed,
                       input int restart_at, input logic [31:0] d0);
        logic [31:0] rd_addr[$], wr_addr[$], wr_data[$];
        int gds[$], pds[$], rds[$];
        int exp_done = 1;
        int ri = 0, wi = 0, dones = 0, gw = 0, pw = 0, k = 0, rv_cnt = 0;
        bit rv_pend = 0;
        int rs;
        for (int i = 0; i < n; i++) begin
            rd_addr.push_back(s + 32'(4 * i));
            wr_addr.push_back(d + 32'(4 * i));
            wr_data.push_back((i == 0 && d0 != 0) ? d0 : $urandom);
            gds.push_back(fixed ? gmax : int'($urandom_range(gmax, 0)));
            pds.push_back(fixed ? pmax : int'($urandom_range(pmax, 0)));
            rds.push_back(fixed ? rmax : int'($urandom_range(rmax, 0)));
            exp_done += 3 + gds[i] + pds[i] + rds[i];
        end
        rs = (restart_at == 0) ? int'($urandom_range(exp_done - 1, 1)) : restart_at;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        start = 1'b1; src_addr = s; dst_addr = d; len = 16'(n);
        @(posedge clk);
        while (k < exp_done + 3) begin
            @(negedge clk);
            k++;
            start = (k == rs);
            if (start) begin
                src_addr = $urandom & ~32'h3; dst_addr = $urandom & ~32'h3; len = 16'd5;
            end
            dmem_rvalid = 1'b0;
            dmem_gnt = 1'($urandom);
            pim_ready = 1'($urandom);
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1; dmem_rdata = wr_data[ri-1]; rv_pend = 0;
                end else rv_cnt--;
            end
            chk("exclusive", 64'(dmem_req & pim_valid), 64'(0));
            chk("busy", 64'(busy), 64'(k <= exp_done));
            chk("done", 64'(done), 64'(k == exp_done));
            if (dmem_req) begin
                chk("rd_addr", 64'(dmem_addr), (ri < n) ? 64'(rd_addr[ri]) : 64'h1_0000_0000);
                dmem_gnt = 1'b0;
                if (ri < n) begin
                    if (gw == gds[ri]) begin
                        dmem_gnt = 1'b1; gw = 0; rv_pend = 1; rv_cnt = rds[ri]; ri++;
                    end else gw++;
                end
            end
            if (pim_valid) begin
                chk("wr_addr", 64'(pim_addr), (wi < n) ? 64'(wr_addr[wi]) : 64'h1_0000_0000);
                chk("wr_data", 64'(pim_wdata), (wi < n) ? 64'(wr_data[wi]) : 64'h1_0000_0000);
                chk("wstrb", 64'(pim_wstrb), 64'(4'hF));
                pim_ready = 1'b0;
                if (wi < n) begin
                    if (pw == pds[wi]) begin
                        pim_ready = 1'b1; pw = 0; wi++;
                    end else pw++;
                end
            end
            if (done) dones++;
        end
        start = 1'b0; dmem_gnt = 1'b0; pim_ready = 1'b0; dmem_rvalid = 1'b0;
        chk("reads", 64'(ri), 64'(n));
        chk("writes", 64'(wi), 64'(n));
        chk("dones", 64'(dones), 64'(1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 64'({busy, done, dmem_req, pim_valid, pim_wstrb}), 64'(0));
        chk("rst_addr", {dmem_addr, pim_addr}, 64'(0));
        rst_n = 1'b1;

        run(32'h100, 32'h8000_0000, 1, 0, 0, 0, 1, -1, 32'hDEAD_BEEF);
        run(32'h100, 32'h4000_0000, 4, 2, 3, 0, 1, -1, 32'h0);
        run(32'h200, 32'h300, 0, 0, 0, 0, 1, -1, 32'h0);
        run(32'h400, 32'h500, 3, 1, 1, 1, 1, 4, 32'h0);
        run(32'hFFFF_FFFC, 32'hFFFF_FFF8, 2, 0, 0, 0, 1, -1, 32'h0);

        // Async reset while a write is stalled in WR.
        @(negedge clk);
        start = 1'b1; src_addr = 32'h700; dst_addr = 32'h900; len = 16'd3;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; pim_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", 64'(pim_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_ctl", 64'({busy, done, dmem_req, pim_valid, pim_wstrb}), 64'(0));
        chk("async_addr", {dmem_addr, pim_addr}, 64'(0));
        chk("async_data", 64'(pim_wdata), 64'(0));
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        dmem_rvalid = 1'b1; pim_ready = 1'b1; dmem_gnt = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ignored", 64'({busy, done, dmem_req, pim_valid}), 64'(0));
        end
        dmem_rvalid = 1'b0; pim_ready = 1'b0; dmem_gnt = 1'b0;
        run(32'hA00, 32'hB00, 1, 0, 0, 0, 1, -1, 32'h0);

        for (int t = 0; t < 8; t++)
            run($urandom & ~32'h3, $urandom & ~32'h3, int'($urandom_range(6, 1)),
                3, 3, 2, 0, (t % 2 == 0) ? 0 : -1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pim_dma_ctrl.md
Name: pim_dma_ctrl

Overview:
- Sequences the word-copy transfer launched by a PIM-opcode instruction when the main decoder asserts its DMA enable.
- Reads words from DMEM through a request/grant master port and writes each word to the PIM write port through a valid/ready port.
- Holds the core pipeline stalled via o_busy until the transfer completes.
- Sits beside the LSU in the EX/MEM stage. It shares the DMEM port through the existing DMEM arbiter, which drives i_dmem_gnt.

Parameters:
- ADDR_W, 32, byte address width of the DMEM and PIM ports.
- DATA_W, 32, data word width; fixed at 32 (strobe width = DATA_W/8).
- LEN_W, 16, width of the transfer length in words; max transfer 2^LEN_W-1 words.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_start  input  1  launch pulse (DMA enable qualified by valid EX instruction)
- i_src_addr  input  ADDR_W  DMEM source byte address (rs1 value), word aligned
- i_dst_addr  input  ADDR_W  PIM destination byte address (rs2 value), word aligned
- i_len  input  LEN_W  number of words to copy
- o_busy  output  1  transfer in progress; core stall request
- o_done  output  1  one-cycle completion pulse
- o_dmem_req  output  1  DMEM read request
- o_dmem_addr  output  ADDR_W  DMEM read address
- i_dmem_gnt  input  1  arbiter grant; request accepted this cycle
- i_dmem_rvalid  input  1  read data valid
- i_dmem_rdata  input  DATA_W  read data
- o_pim_valid  output  1  PIM write valid
- o_pim_addr  output  ADDR_W  PIM write address
- o_pim_wdata  output  DATA_W  PIM write data
- o_pim_wstrb  output  DATA_W/8  byte strobes; always all ones while valid
- i_pim_ready  input  1  PIM accepts write this cycle

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE; all outputs 0; src/dst/count/data registers 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- o_busy = (state != IDLE), registered-state decode.
- IDLE:
  - On i_start, latch i_src_addr, i_dst_addr and i_len.
  - If i_len == 0, go to DONE; otherwise go to RD_REQ.
  - i_start outside IDLE is ignored; there is no queueing.
- RD_REQ:
  - o_dmem_req=1 and o_dmem_addr=src.
  - Request and address are held stable until i_dmem_gnt.
  - On gnt, go to RD_WAIT.
- RD_WAIT:
  - Wait for i_dmem_rvalid, which arrives no earlier than the cycle after gnt.
  - On rvalid, capture i_dmem_rdata into the data register and go to WR.
  - rvalid in any other state is ignored.
- WR:
  - o_pim_valid=1, o_pim_addr=dst, o_pim_wdata=data register, o_pim_wstrb=all ones.
  - Valid, address and data are held until i_pim_ready.
  - On ready: src+=4, dst+=4, count-=1. If count was 1, go to DONE; otherwise go to RD_REQ.
- DONE: o_done=1 for exactly one cycle, o_busy still 1; then go to IDLE.
- Minimum latency per word with gnt, rvalid and ready immediate: 3 cycles (RD_REQ, RD_WAIT, WR).
- Total transfer with immediate handshakes: 3N+1 cycles from start accept to o_done.
- Address arithmetic is modulo 2^ADDR_W; wrap past 0xFFFF_FFFC to 0x0 is silent.
- Low address bits [1:0] are passed through unmodified; alignment is the software's responsibility.
- Reset mid-transfer: immediate return to IDLE with outputs 0. Any outstanding DMEM read is dropped, and a late rvalid is ignored.
- o_dmem_req and o_pim_valid are never asserted in the same cycle.

Decomposition:
- Shared package pim_pkg holds:
  - the FSM state enum (dma_state_e);
  - WORD_BYTES=4 and the default LEN_W.
- Sub-module: none required. The FSM plus address/count registers fit in a single module.
- The datapath registers may be split into pim_dma_regs if it exceeds ~250 lines.

Test Plan:
- Single word, immediate handshakes: start src=0x100, dst=0x8000_0000, len=1, rdata=0xDEADBEEF.
  - Expect req@addr 0x100, one PIM write of 0xDEADBEEF to 0x8000_0000 with wstrb=4'hF.
  - Expect o_done 4 cycles after start; o_busy high for exactly 4 cycles.
- Four words with gnt delayed 2 cycles and ready delayed 3 cycles per word:
  - Expect DMEM addresses 0x100, 0x104, 0x108, 0x10C and PIM addresses dst+0/4/8/C, in order.
  - Expect addr, data and valid stable while stalled, and exactly one o_done.
- Zero length: start with len=0 → no o_dmem_req and no o_pim_valid; o_done one cycle after start; o_busy high for 1 cycle.
- Start while busy: second i_start during a len=3 transfer is ignored; exactly 3 writes occur and the latched addresses are unchanged.
- Wrap: src=0xFFFF_FFFC, len=2 → DMEM addresses 0xFFFF_FFFC then 0x0000_0000.
- Async reset asserted during WR: outputs 0 immediately, without waiting for a clock edge.
  - After release, a stray i_dmem_rvalid and i_pim_ready cause no activity.
  - A new start with len=1 completes normally.
